// File: rtl/stream_div_pkg.sv
// Shared types and helpers for the byte-stream divider and its iterative core.
package stream_div_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_DIVIDEND,
    ST_LOAD_DIVISOR,
    ST_DIVIDE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CORE_IDLE,
    CORE_ITER,
    CORE_FIX
  } core_state_e;

  function automatic int bytes_per_op(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/stream_divider_if.sv
// Byte-stream input, operation control and result signals of stream_divider.
interface stream_divider_if #(
  parameter int WIDTH_P = 32,
  parameter int LEN_W_P = 16
);

  logic               valid_i;
  logic [7:0]         data_i;
  logic               ready_o;
  logic               start_i;
  logic [LEN_W_P-1:0] len_i;
  logic               signed_i;
  logic               done_o;
  logic               busy_o;
  logic [WIDTH_P-1:0] result_o;
  logic [WIDTH_P-1:0] remainder_o;
  logic               div_by_zero_o;

  modport slave (
    input  valid_i, data_i, start_i, len_i, signed_i,
    output ready_o, done_o, busy_o, result_o, remainder_o, div_by_zero_o
  );

  modport master (
    output valid_i, data_i, start_i, len_i, signed_i,
    input  ready_o, done_o, busy_o, result_o, remainder_o, div_by_zero_o
  );

endinterface

// File: rtl/div_core.sv
// Restoring shift-subtract divider, one quotient bit per cycle, with signed
// magnitude handling and a defined divide-by-zero result.
module div_core
  import stream_div_pkg::*;
#(
  parameter int WIDTH_P = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [WIDTH_P-1:0] dividend_i,
  input  logic [WIDTH_P-1:0] divisor_i,
  output logic               done_o,
  output logic [WIDTH_P-1:0] quotient_o,
  output logic [WIDTH_P-1:0] remainder_o,
  output logic               dbz_o
);

  localparam int CNT_W = $clog2(WIDTH_P);

  core_state_e        state_reg, state_next;
  logic [WIDTH_P-1:0] quo_reg, quo_next;
  logic [WIDTH_P-1:0] rem_reg, rem_next;
  logic [WIDTH_P-1:0] div_reg, div_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic               dbz_reg, dbz_next;
  logic               done_reg, done_next;
  logic [WIDTH_P-1:0] quot_out_reg, quot_out_next;
  logic [WIDTH_P-1:0] rem_out_reg, rem_out_next;

  logic               a_neg, d_neg;
  logic [WIDTH_P-1:0] a_mag, d_mag;
  logic [WIDTH_P:0]   shifted;
  logic               q_bit;

  assign a_neg   = signed_i & dividend_i[WIDTH_P-1];
  assign d_neg   = signed_i & divisor_i[WIDTH_P-1];
  assign a_mag   = a_neg ? -dividend_i : dividend_i;
  assign d_mag   = d_neg ? -divisor_i : divisor_i;
  // The partial remainder stays below the divisor, so the trial value fits WIDTH_P+1 bits.
  assign shifted = {rem_reg, quo_reg[WIDTH_P-1]};
  assign q_bit   = shifted >= {1'b0, div_reg};

  always_comb begin
    state_next    = state_reg;
    quo_next      = quo_reg;
    rem_next      = rem_reg;
    div_next      = div_reg;
    cnt_next      = cnt_reg;
    neg_q_next    = neg_q_reg;
    neg_r_next    = neg_r_reg;
    dbz_next      = dbz_reg;
    done_next     = 1'b0;
    quot_out_next = quot_out_reg;
    rem_out_next  = rem_out_reg;

    case (state_reg)
      CORE_IDLE: begin
        if (start_i) begin
          if (divisor_i == '0) begin
            // Skip iteration; the fixup cycle publishes all-ones / dividend unchanged.
            quo_next   = '1;
            rem_next   = dividend_i;
            neg_q_next = 1'b0;
            neg_r_next = 1'b0;
            dbz_next   = 1'b1;
            state_next = CORE_FIX;
          end else begin
            quo_next   = a_mag;
            rem_next   = '0;
            div_next   = d_mag;
            cnt_next   = '0;
            neg_q_next = a_neg ^ d_neg;
            neg_r_next = a_neg;
            dbz_next   = 1'b0;
            state_next = CORE_ITER;
          end
        end
      end
      CORE_ITER: begin
        rem_next = q_bit ? (shifted[WIDTH_P-1:0] - div_reg) : shifted[WIDTH_P-1:0];
        quo_next = {quo_reg[WIDTH_P-2:0], q_bit};
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == CNT_W'(WIDTH_P - 1)) begin
          state_next = CORE_FIX;
        end
      end
      CORE_FIX: begin
        quot_out_next = neg_q_reg ? -quo_reg : quo_reg;
        rem_out_next  = neg_r_reg ? -rem_reg : rem_reg;
        done_next     = 1'b1;
        state_next    = CORE_IDLE;
      end
      default: state_next = CORE_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= CORE_IDLE;
      quo_reg      <= '0;
      rem_reg      <= '0;
      div_reg      <= '0;
      cnt_reg      <= '0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      dbz_reg      <= 1'b0;
      done_reg     <= 1'b0;
      quot_out_reg <= '0;
      rem_out_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      quo_reg      <= quo_next;
      rem_reg      <= rem_next;
      div_reg      <= div_next;
      cnt_reg      <= cnt_next;
      neg_q_reg    <= neg_q_next;
      neg_r_reg    <= neg_r_next;
      dbz_reg      <= dbz_next;
      done_reg     <= done_next;
      quot_out_reg <= quot_out_next;
      rem_out_reg  <= rem_out_next;
    end
  end

  assign done_o      = done_reg;
  assign quotient_o  = quot_out_reg;
  assign remainder_o = rem_out_reg;
  assign dbz_o       = dbz_reg;

endmodule

// File: rtl/stream_divider.sv
// Collects a dividend and a chain of divisors as big-endian byte streams and
// divides them in sequence through div_core, holding the final result.
module stream_divider
  import stream_div_pkg::*;
#(
  parameter int WIDTH_P = 32,
  parameter int LEN_W_P = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  stream_divider_if.slave bus
);

  localparam int NB   = bytes_per_op(WIDTH_P);
  localparam int BC_W = $clog2(NB + 1);

  state_e             state_reg, state_next;
  logic [BC_W-1:0]    byte_cnt_reg, byte_cnt_next;
  logic [LEN_W_P-1:0] chain_cnt_reg, chain_cnt_next;
  logic [WIDTH_P-1:0] acc_reg, acc_next;
  logic [WIDTH_P-1:0] dividend_reg, dividend_next;
  logic [WIDTH_P-1:0] result_reg, result_next;
  logic [WIDTH_P-1:0] remainder_reg, remainder_next;
  logic               signed_reg, signed_next;
  logic               dbz_reg, dbz_next;
  logic               core_start_reg, core_start_next;

  logic               ready;
  logic               accept;
  logic               last_byte;
  logic [WIDTH_P-1:0] acc_shift;
  logic               core_done;
  logic               core_dbz;
  logic [WIDTH_P-1:0] core_quotient;
  logic [WIDTH_P-1:0] core_remainder;

  assign ready     = (state_reg == ST_LOAD_DIVIDEND) || (state_reg == ST_LOAD_DIVISOR);
  assign accept    = bus.valid_i && ready;
  assign acc_shift = (acc_reg << 8) | WIDTH_P'(bus.data_i);
  assign last_byte = byte_cnt_reg == BC_W'(NB - 1);

  // The divisor is read straight from the accumulator; no bytes are accepted while dividing.
  div_core #(
    .WIDTH_P (WIDTH_P)
  ) u_core (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (core_start_reg),
    .signed_i    (signed_reg),
    .dividend_i  (dividend_reg),
    .divisor_i   (acc_reg),
    .done_o      (core_done),
    .quotient_o  (core_quotient),
    .remainder_o (core_remainder),
    .dbz_o       (core_dbz)
  );

  always_comb begin
    state_next      = state_reg;
    byte_cnt_next   = byte_cnt_reg;
    chain_cnt_next  = chain_cnt_reg;
    acc_next        = acc_reg;
    dividend_next   = dividend_reg;
    result_next     = result_reg;
    remainder_next  = remainder_reg;
    signed_next     = signed_reg;
    dbz_next        = dbz_reg;
    core_start_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (bus.start_i) begin
          signed_next    = bus.signed_i;
          chain_cnt_next = (bus.len_i == '0) ? LEN_W_P'(1) : bus.len_i;
          result_next    = '0;
          remainder_next = '0;
          dbz_next       = 1'b0;
          byte_cnt_next  = '0;
          acc_next       = '0;
          state_next     = ST_LOAD_DIVIDEND;
        end
      end
      ST_LOAD_DIVIDEND: begin
        if (accept) begin
          acc_next = acc_shift;
          if (last_byte) begin
            byte_cnt_next = '0;
            dividend_next = acc_shift;
            state_next    = ST_LOAD_DIVISOR;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
          end
        end
      end
      ST_LOAD_DIVISOR: begin
        if (accept) begin
          acc_next = acc_shift;
          if (last_byte) begin
            byte_cnt_next   = '0;
            core_start_next = 1'b1;
            state_next      = ST_DIVIDE;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
          end
        end
      end
      ST_DIVIDE: begin
        if (core_done) begin
          dividend_next  = core_quotient;
          chain_cnt_next = chain_cnt_reg - 1'b1;
          dbz_next       = dbz_reg | core_dbz;
          if (chain_cnt_reg == LEN_W_P'(1)) begin
            result_next    = core_quotient;
            remainder_next = core_remainder;
            state_next     = ST_DONE;
          end else begin
            state_next = ST_LOAD_DIVISOR;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= ST_IDLE;
      byte_cnt_reg   <= '0;
      chain_cnt_reg  <= '0;
      acc_reg        <= '0;
      dividend_reg   <= '0;
      result_reg     <= '0;
      remainder_reg  <= '0;
      signed_reg     <= 1'b0;
      dbz_reg        <= 1'b0;
      core_start_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      byte_cnt_reg   <= byte_cnt_next;
      chain_cnt_reg  <= chain_cnt_next;
      acc_reg        <= acc_next;
      dividend_reg   <= dividend_next;
      result_reg     <= result_next;
      remainder_reg  <= remainder_next;
      signed_reg     <= signed_next;
      dbz_reg        <= dbz_next;
      core_start_reg <= core_start_next;
    end
  end

  assign bus.ready_o       = ready;
  assign bus.busy_o        = state_reg != ST_IDLE;
  assign bus.done_o        = state_reg == ST_DONE;
  assign bus.result_o      = result_reg;
  assign bus.remainder_o   = remainder_reg;
  assign bus.div_by_zero_o = dbz_reg;

endmodule

// File: doc/stream_divider.md
# stream_divider

Parametrised byte-stream divider for the UART ALU datapath. After `start_i` it collects one dividend and `len_i` divisors as big-endian byte streams from the UART receive path. It performs a chained integer division ((a / d1) / d2) ... in a built-in iterative restoring core, and reports quotient, remainder and a divide-by-zero flag to the ALU result mux. Compared with the fixed 32-bit unsigned divider it adds operand width, signed mode, operation chaining, remainder output and defined divide-by-zero behaviour.

## Interface
- `WIDTH_P`, 32: operand/result width in bits; multiple of 8, range 8..64. `NB = WIDTH_P/8` bytes per operand.
- `LEN_W_P`, 16: width of `len_i`.
- `clk_i`  in  1  clock; all state on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  byte strobe from the UART receive path.
- `data_i`  in  8  byte; operands MSB byte first.
- `ready_o`  out  1  byte accepted on `valid_i && ready_o`.
- `start_i`  in  1  begin an operation; sampled only in Idle.
- `len_i`  in  LEN_W_P  number of divisors; sampled with `start_i`; 0 treated as 1.
- `signed_i`  in  1  1 = two's-complement division; sampled with `start_i`.
- `done_o`  out  1  one-cycle pulse when the final result is valid.
- `busy_o`  out  1  high in every state except Idle.
- `result_o`  out  WIDTH_P  final quotient; held until the next accepted `start_i`.
- `remainder_o`  out  WIDTH_P  remainder of the last division step; held like `result_o`.
- `div_by_zero_o`  out  1  sticky for the operation: any step had divisor 0. Held like `result_o`.

## Operation
- States: Idle, LoadDividend, LoadDivisor, Divide, Done.
- Idle:
  - `ready_o=0`.
  - On `start_i`: latch len/signed, clear the result registers and `div_by_zero_o`, byte count 0, then go to LoadDividend.
- LoadDividend: `ready_o=1`. Each accepted byte shifts into the accumulator from the LSB side (first byte ends up as MSB). After NB bytes, go to LoadDivisor.
- LoadDivisor: `ready_o=1`. Collects NB bytes the same way. After the NB-th byte, pulse the core start and go to Divide.
- Divide:
  - `ready_o=0`; bytes offered here are dropped and do not stall.
  - On core done:
    - quotient becomes the next dividend;
    - decrement the remaining count;
    - if the count is now 0, load result/remainder and go to Done; otherwise go to LoadDivisor.
- Done: `done_o=1` for one cycle, then go to Idle.
- Core arithmetic (div_core):
  - Signed mode divides magnitudes, then negates: the quotient when operand signs differ, the remainder when the dividend is negative. Quotient truncates toward zero; the remainder takes the dividend's sign.
  - MIN / -1 (signed): quotient = MIN (wraps), remainder 0, no flag.
  - Divisor 0, either mode: quotient all-ones, remainder = dividend, set `div_by_zero_o`. No iteration; core done the cycle after start. The chain continues with all-ones as the dividend.
- `start_i` outside Idle is ignored. `len_i`/`signed_i` changes after sampling have no effect.
- Reset at any time: immediately to Idle, with all outputs 0 (`ready_o`, `busy_o`, `done_o`, `result_o`, `remainder_o`, `div_by_zero_o`).

## Timing
- Byte acceptance: one byte per cycle maximum; gaps in `valid_i` are allowed anywhere.
- Core latency, nonzero divisor:
  - start registered 1 cycle after the last divisor byte edge;
  - WIDTH_P iteration cycles;
  - 1 sign-fixup cycle.
  - Core done is therefore WIDTH_P+2 cycles after the last byte edge.
- Core latency, zero divisor: core done 2 cycles after the last byte edge.
- `done_o` is high in the cycle after the final core done.
  - Single step, WIDTH_P=32, nonzero divisor: last byte accepted at edge k, `done_o` high during cycle k+35.
- `ready_o` reasserts for the next divisor in the cycle after each intermediate core done.
- `result_o`/`remainder_o` are valid in the same cycle as `done_o` and stay stable until the next `start_i` is accepted.

## Structure
- Package `stream_div_pkg`:
  - `state_e` enum (Idle..Done);
  - `div_core` state enum (CoreIdle, CoreIter, CoreFix);
  - function `bytes_per_op(width)`.
- Sub-module `div_core #(WIDTH_P)`:
  - restoring shift-subtract, one quotient bit per cycle;
  - inputs: start, signed, dividend, divisor;
  - outputs: done pulse, quotient, remainder, dbz.
- Top level holds the byte counter, chain counter, operand accumulator and output registers.

## Test plan
- WIDTH_P=32, unsigned, len 1: 100 / 7 → result 14, remainder 2, `div_by_zero_o` 0, `done_o` exactly 35 cycles after the last byte edge.
- Signed, len 1: -7 / 2 → result 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 0x80000000 / 0xFFFFFFFF → result 0x80000000, remainder 0.
- Unsigned chain, len 3: 1000 / 2 / 5 / 3 → result 33, remainder 1. `ready_o` low throughout each Divide phase; `done_o` pulses once.
- Divide by zero, len 2: 5 / 0 / 1 → result 0xFFFFFFFF, remainder 0, `div_by_zero_o` 1.
- Protocol: random `valid_i` gaps give identical results. Bytes offered during Divide and `start_i` while busy are ignored. `len_i`=0 behaves as 1.
- WIDTH_P=16: 0x1234 / 0x0010 → 0x0123, remainder 4. Deassert `rst_ni` mid-Divide → all outputs 0 immediately; a following operation is correct.
